// File: rtl/muxer_scheduler.sv
// Time-multiplexed scheduler for a shared 4-bit datapath: drives a select,
// waits DWELL cycles for the result to settle, then captures it.
module muxer_scheduler #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mux_in,
    input  logic       auto_en,
    input  logic       req,
    input  logic [1:0] req_sel,
    output logic [1:0] sel,
    output logic       ack,
    output logic [3:0] last_res,
    output logic [3:0] res0,
    output logic [3:0] res1,
    output logic [3:0] res2,
    output logic       sweep_done,
    output logic       busy
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SEL_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] AIDX_LAST = SEL_W'(2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] aidx;
    logic [CNT_W-1:0] cnt;
    logic             manual;

    // Scheduler FSM; every output is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            aidx       <= '0;
            cnt        <= '0;
            manual     <= 1'b0;
            ack        <= 1'b0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
            last_res   <= '0;
            res0       <= '0;
            res1       <= '0;
            res2       <= '0;
        end else begin
            ack        <= 1'b0;
            sweep_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        sel    <= req_sel;
                        cnt    <= CNT_LOAD;
                        manual <= 1'b1;
                        state  <= SETTLE;
                        busy   <= 1'b1;
                    end else if (auto_en) begin
                        sel    <= aidx;
                        cnt    <= CNT_LOAD;
                        manual <= 1'b0;
                        state  <= SETTLE;
                        busy   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    last_res <= mux_in;
                    case (sel)
                        2'd0:    res0 <= mux_in;
                        2'd1:    res1 <= mux_in;
                        2'd2:    res2 <= mux_in;
                        default: ;
                    endcase
                    // Manual captures leave the sweep position untouched.
                    if (manual) begin
                        ack <= 1'b1;
                    end else begin
                        sweep_done <= (aidx == AIDX_LAST);
                        aidx       <= (aidx == AIDX_LAST) ? '0 : aidx + SEL_W'(1);
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/muxer_scheduler.md
MUXER_SCHEDULER -- requirements
Module: muxer_scheduler

Interface
REQ-001 SHALL have parameter DWELL, default 4: cycles `sel` is held stable before `mux_in` is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mux_in  input  4  result returned by the shared datapath for the current `sel`.
REQ-005 SHALL have port auto_en  input  1  level; enables continuous sweep of modes 0,1,2.
REQ-006 SHALL have port req  input  1  level; manual single-shot evaluation request.
REQ-007 SHALL have port req_sel  input  2  mode for a manual request; sampled only when `req` is accepted.
REQ-008 SHALL have port sel  output  2  registered select driven to the datapath.
REQ-009 SHALL have port ack  output  1  one-cycle pulse; manual result is valid on `last_res`.
REQ-010 SHALL have port last_res  output  4  most recently captured value.
REQ-011 SHALL have port res0, res1, res2  output  4 each  latest captured result for modes 0, 1 and 2.
REQ-012 SHALL have port sweep_done  output  1  one-cycle pulse after an auto capture of mode 2.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE and CAPTURE, plus a 2-bit auto index `aidx` (0..2) and a 4-bit dwell counter `cnt`.
REQ-015 In IDLE with `req`=1, the block SHALL load `sel`<=`req_sel`, `cnt`<=DWELL-1 and mode flag manual, then go to SETTLE; `req` has priority over `auto_en`.
REQ-016 In IDLE with `req`=0 and `auto_en`=1, the block SHALL load `sel`<=`aidx`, `cnt`<=DWELL-1 and mode flag auto, then go to SETTLE.
REQ-017 In IDLE with `req`=0 and `auto_en`=0, the block SHALL remain in IDLE with `sel` unchanged.
REQ-018 In SETTLE, the block SHALL decrement `cnt` each cycle and go to CAPTURE on the cycle `cnt`=0, giving exactly DWELL SETTLE cycles.
REQ-019 In CAPTURE, the block SHALL register `mux_in` into `last_res` and into `res[sel]`, then go to IDLE; `sel`=3 updates only `last_res`.
REQ-020 On a manual capture, `ack`=1 SHALL be asserted for exactly the one cycle following CAPTURE.
REQ-021 Latency: a `req` accepted at edge k SHALL yield `ack` high after edge k+DWELL+1.
REQ-022 On an auto capture, the block SHALL advance `aidx` 0->1->2->0; capturing mode 2 SHALL pulse `sweep_done` for one cycle, aligned as `ack` is.
REQ-023 A manual capture SHALL NOT change `aidx`; the auto sweep resumes at the interrupted index.
REQ-024 `req`, `req_sel` and `auto_en` SHALL be ignored while `busy`=1; no request queueing.
REQ-025 `req` still high in the IDLE cycle after `ack` SHALL be accepted as a new request; requesters drop `req` on `ack`.
REQ-026 `auto_en` falling mid-step SHALL let the current step finish, including capture and `aidx` advance, then remain in IDLE.
REQ-027 `ack` and `sweep_done` SHALL never both be high in the same cycle.
REQ-028 `sel` SHALL change only on the IDLE->SETTLE transition and SHALL be stable through SETTLE and CAPTURE.

Reset
REQ-029 When `rst_n`=0, the block SHALL immediately force state=IDLE, `sel`=0, `aidx`=0, `cnt`=0, `ack`=0, `sweep_done`=0, `busy`=0, `last_res`=0 and res0..res2=0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no `ack` and no result update; the first edge after release SHALL evaluate IDLE rules.

Verification
REQ-031 Scenario: DWELL=4, `auto_en`=0, `req`=1 with `req_sel`=1 and `mux_in`=5 at edge 0 -> `sel`=1 from edge 0, `busy`=1 for 5 cycles, `ack`=1 and `last_res`=`res1`=5 after edge 5.
REQ-032 Scenario: `auto_en`=1 with `mux_in` tracking `sel` as 2,5,1 -> `sel` sequence 0,1,2 each held 5 cycles plus 1 IDLE cycle; `res0`=2, `res1`=5, `res2`=1; one `sweep_done` pulse; `ack` stays 0.
REQ-033 Scenario: `auto_en`=1 with `req` (`req_sel`=0) raised during the mode-1 SETTLE -> mode-1 step completes, then the manual request is served (`sel`=0, `ack`), then the sweep resumes at mode 2.
REQ-034 Scenario: manual `req_sel`=3 with `mux_in`=0 -> `ack` pulses, `last_res`=0, res0..res2 unchanged.
REQ-035 Scenario: `rst_n` driven low 2 cycles into SETTLE -> all outputs reset to 0 asynchronously; no `ack` after release while `req`=0.
REQ-036 Scenario: DWELL=1 with manual request at edge 0 -> `ack` after edge 2.
